// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling-message sequencer: FSM state
// encoding, default timing/geometry constants and the anode decode helper.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_TICK_DIV = 8388608;
  localparam int DEF_MUX_DIV  = 65536;
  localparam int DEF_MSG_LEN  = 16;
  localparam int DEF_DIGITS   = 4;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low one-hot anode for a refresh slot; slot 0 is the leftmost
  // digit and maps to anode[3].
  function automatic logic [3:0] anode_for(input logic [1:0] sel);
    return ~(4'b1000 >> sel);
  endfunction

endpackage

// File: rtl/scroll_ctrl_if.sv
// Control/display bundle between the user controls, the sequencer and the
// message ROM + 7-segment decoder. The master side drives run/step/dir,
// the slave side (the sequencer) drives the display addressing outputs.
interface scroll_ctrl_if
  import scroll_pkg::*;
#(
  parameter int MSG_LEN = DEF_MSG_LEN
) ();

  localparam int PW = $clog2(MSG_LEN);

  logic          run;
  logic          step;
  logic          dir;
  logic [PW-1:0] ptr;
  logic [1:0]    digit_sel;
  logic [3:0]    anode;
  logic [PW-1:0] char_addr;
  logic          shift_en;
  logic          wrap;

  modport master (
    output run, step, dir,
    input  ptr, digit_sel, anode, char_addr, shift_en, wrap
  );

  modport slave (
    input  run, step, dir,
    output ptr, digit_sel, anode, char_addr, shift_en, wrap
  );

endinterface

// File: rtl/scroll_ctrl_tick_gen.sv
// Down-counting period generator: counts DIV-1..0 while enabled and reloads,
// asserting tick during the cycle the count reads 0. clr forces the reload
// value so a restart always begins a full period.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW     = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Period counter: hold at reload when cleared, otherwise count down and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= RELOAD;
    end else if (clr) begin
      r_cnt <= RELOAD;
    end else if (en) begin
      r_cnt <= (r_cnt == {CW{1'b0}}) ? RELOAD : (r_cnt - CW'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tick = en && (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/scroll_ctrl.sv
// Scrolling-message sequencer: IDLE/RUN/HOLD control of the message window
// pointer, scroll-rate and refresh-rate timing, anode multiplexing and the
// per-slot message address.
// Optional feature macro: SCROLL_DIR_EN (when defined, dir selects right
// scrolling; otherwise the window always moves left and dir is unused).
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int MUX_DIV  = DEF_MUX_DIV,
  parameter int MSG_LEN  = DEF_MSG_LEN,
  parameter int DIGITS   = DEF_DIGITS
) (
  input  logic         clk,
  input  logic         reset,
  scroll_ctrl_if.slave bus
);

  localparam int            PW         = $clog2(MSG_LEN);
  localparam logic [PW-1:0] LAST_IDX   = PW'(MSG_LEN - 1);
  localparam logic [PW:0]   LEN_EXT    = (PW + 1)'(MSG_LEN);
  localparam logic [1:0]    LAST_DIGIT = 2'(DIGITS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_adv;
  logic          w_wrap_nxt;
  logic [1:0]    r_digit_sel;
  logic [1:0]    w_digit_sel_nxt;
  logic [3:0]    r_anode;
  logic [3:0]    w_anode_nxt;
  logic          r_shift_en;
  logic          r_wrap;
  logic          w_scroll_tick;
  logic          w_mux_tick;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_char_addr;

  // Scroll timing only runs in RUN; HOLD/IDLE keep it parked at reload so
  // entering RUN always starts a full scroll period.
  tick_gen #(.DIV(TICK_DIV)) u_scroll_tick (
    .clk   (clk),
    .reset (reset),
    .en    (r_state == RUN),
    .clr   (r_state != RUN),
    .tick  (w_scroll_tick)
  );

  // Refresh timing runs whenever the display is lit.
  tick_gen #(.DIV(MUX_DIV)) u_mux_tick (
    .clk   (clk),
    .reset (reset),
    .en    (r_state != IDLE),
    .clr   (r_state == IDLE),
    .tick  (w_mux_tick)
  );

  // Next-state and advance request; a falling run beats a pending scroll
  // tick, and run beats step in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.run) begin
          w_state_nxt = RUN;
        end else if (bus.step) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!bus.run) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = RUN;
          w_adv       = w_scroll_tick;
        end
      end
      HOLD: begin
        if (bus.run) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = HOLD;
          w_adv       = bus.step;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_adv       = 1'b0;
      end
    endcase
  end

  // Pointer advance with compare-and-wrap in the selected direction.
  always_comb begin
    w_ptr_nxt  = r_ptr;
    w_wrap_nxt = 1'b0;
    if (w_adv) begin
`ifdef SCROLL_DIR_EN
      if (bus.dir) begin
        if (r_ptr == {PW{1'b0}}) begin
          w_ptr_nxt  = LAST_IDX;
          w_wrap_nxt = 1'b1;
        end else begin
          w_ptr_nxt  = r_ptr - PW'(1);
          w_wrap_nxt = 1'b0;
        end
      end else if (r_ptr == LAST_IDX) begin
        w_ptr_nxt  = {PW{1'b0}};
        w_wrap_nxt = 1'b1;
      end else begin
        w_ptr_nxt  = r_ptr + PW'(1);
        w_wrap_nxt = 1'b0;
      end
`else
      if (r_ptr == LAST_IDX) begin
        w_ptr_nxt  = {PW{1'b0}};
        w_wrap_nxt = 1'b1;
      end else begin
        w_ptr_nxt  = r_ptr + PW'(1);
        w_wrap_nxt = 1'b0;
      end
`endif
    end else begin
      w_ptr_nxt  = r_ptr;
      w_wrap_nxt = 1'b0;
    end
  end

`ifndef SCROLL_DIR_EN
  logic w_unused_dir;
  assign w_unused_dir = bus.dir;
`endif

  // Refresh slot and its anode; the anode follows the next state/slot so
  // both registers change together.
  always_comb begin
    w_digit_sel_nxt = r_digit_sel;
    if (r_state == IDLE) begin
      w_digit_sel_nxt = 2'd0;
    end else if (w_mux_tick) begin
      w_digit_sel_nxt = (r_digit_sel == LAST_DIGIT) ? 2'd0 : (r_digit_sel + 2'd1);
    end else begin
      w_digit_sel_nxt = r_digit_sel;
    end
    if (w_state_nxt == IDLE) begin
      w_anode_nxt = ANODE_OFF;
    end else begin
      w_anode_nxt = anode_for(w_digit_sel_nxt);
    end
  end

  // Sequencer state and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= {PW{1'b0}};
      r_digit_sel <= 2'd0;
      r_anode     <= ANODE_OFF;
      r_shift_en  <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_digit_sel <= w_digit_sel_nxt;
      r_anode     <= w_anode_nxt;
      r_shift_en  <= w_adv;
      r_wrap      <= w_wrap_nxt;
    end
  end

  // Visible character address: one add, then one conditional subtract.
  always_comb begin
    w_sum = {1'b0, r_ptr} + {{(PW-1){1'b0}}, r_digit_sel};
    if (w_sum >= LEN_EXT) begin
      w_char_addr = PW'(w_sum - LEN_EXT);
    end else begin
      w_char_addr = PW'(w_sum);
    end
  end

  assign bus.ptr       = r_ptr;
  assign bus.digit_sel = r_digit_sel;
  assign bus.anode     = r_anode;
  assign bus.char_addr = w_char_addr;
  assign bus.shift_en  = r_shift_en;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Self-checking bench for scroll_ctrl with TICK_DIV=4, MUX_DIV=2, MSG_LEN=6.
// Expected pointer updates are queued when stimulus is applied and popped
// when the DUT signals shift_en.
module tb_scroll_ctrl;

  logic clk = 1'b0;
  logic reset;

  scroll_ctrl_if #(.MSG_LEN(6)) bus ();

  scroll_ctrl #(
    .TICK_DIV (4),
    .MUX_DIV  (2),
    .MSG_LEN  (6),
    .DIGITS   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ptr;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a shift_en pulse; lat = negedges waited, -1 on timeout.
  task automatic wait_shift(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.shift_en !== 1'b1 && lat < budget);
    if (bus.shift_en !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.run = 1'b0;
    bus.step = 1'b0;
    bus.dir = 1'b0;
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_cmp++;
      if ({bus.anode, bus.ptr, bus.shift_en, bus.wrap, bus.digit_sel, bus.char_addr} !==
          {4'b1111, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0}) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: anode=%b ptr=%0d sh=%b wr=%b ds=%0d ca=%0d, want 1111/0/0/0/0/0",
                 i, bus.anode, bus.ptr, bus.shift_en, bus.wrap, bus.digit_sel, bus.char_addr);
      end
    end
  endtask

  task automatic test_run_wrap();
    int   lat;
    int   want_lat;
    exp_t e;
    bus.run = 1'b1;
    for (int k = 1; k <= 10; k++) sb.push_back('{ptr: 3'(k % 6), wrap: (k == 6)});
    for (int k = 1; k <= 10; k++) begin
      want_lat = (k == 1) ? 5 : 3;
      wait_shift(8, lat);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== want_lat) begin
        n_err++;
        $display("FAIL run_latency adv%0d: got %0d cycles, want %0d", k, lat, want_lat);
      end
      n_cmp++;
      if ({bus.ptr, bus.wrap} !== e) begin
        n_err++;
        $display("FAIL run_ptr adv%0d: ptr=%0d wrap=%b, want ptr=%0d wrap=%b", k, bus.ptr, bus.wrap, e.ptr, e.wrap);
      end
      cyc(1);
      n_cmp++;
      if ({bus.shift_en, bus.wrap} !== 2'b00) begin
        n_err++;
        $display("FAIL run_pulse_width adv%0d: shift_en=%b wrap=%b, want 0 0", k, bus.shift_en, bus.wrap);
      end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_mux();
    logic [2:0] exp_addr[8];
    logic [3:0] exp_an[8];
    int  prev;
    bit  found;
    exp_addr = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd0, 3'd0, 3'd1, 3'd1};
    exp_an   = '{4'b0111, 4'b0111, 4'b1011, 4'b1011, 4'b1101, 4'b1101, 4'b1110, 4'b1110};
    prev = -1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (prev == 3 && bus.digit_sel == 2'd0) found = 1'b1;
      prev = int'(bus.digit_sel);
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mux_slot_wrap: digit_sel never went 3->0 (last %0d), want wrap to 0", prev);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus.char_addr, bus.anode} !== {exp_addr[i], exp_an[i]}) begin
        n_err++;
        $display("FAIL mux_slot cyc%0d: char_addr=%0d anode=%b, want %0d %b",
                 i, bus.char_addr, bus.anode, exp_addr[i], exp_an[i]);
      end
      cyc(1);
    end
  endtask

  task automatic test_step();
    int   lat;
    exp_t e;
    sb.push_back('{ptr: 3'd5, wrap: 1'b0});
    sb.push_back('{ptr: 3'd0, wrap: 1'b1});
    sb.push_back('{ptr: 3'd1, wrap: 1'b0});
    for (int j = 0; j < 3; j++) begin
      bus.step = 1'b1;
      wait_shift(1, lat);
      bus.step = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (lat !== 1) begin
        n_err++;
        $display("FAIL step_latency step%0d: got %0d, want 1", j, lat);
      end
      n_cmp++;
      if ({bus.ptr, bus.wrap} !== e) begin
        n_err++;
        $display("FAIL step_ptr step%0d: ptr=%0d wrap=%b, want ptr=%0d wrap=%b", j, bus.ptr, bus.wrap, e.ptr, e.wrap);
      end
      for (int c = 0; c < 4; c++) begin
        cyc(1);
        n_cmp++;
        if (bus.shift_en !== 1'b0) begin
          n_err++;
          $display("FAIL hold_quiet step%0d cyc%0d: shift_en=%b, want 0", j, c, bus.shift_en);
        end
      end
    end
    n_cmp++;
    if (bus.ptr !== 3'd1) begin
      n_err++;
      $display("FAIL step_total: ptr=%0d, want 1", bus.ptr);
    end
  endtask

  task automatic test_run_drop_on_tick();
    bus.run = 1'b1;
    cyc(4);
    bus.run = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cyc(1);
      n_cmp++;
      if ({bus.ptr, bus.shift_en} !== {3'd1, 1'b0}) begin
        n_err++;
        $display("FAIL drop_on_tick cyc%0d: ptr=%0d shift_en=%b, want 1 0", c, bus.ptr, bus.shift_en);
      end
    end
  endtask

  task automatic test_dir();
    int   lat;
    exp_t e;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    bus.step = 1'b1;
    cyc(1);
    bus.step = 1'b0;
    cyc(1);
    n_cmp++;
    if ({bus.ptr, bus.shift_en, bus.anode} !== {3'd0, 1'b0, 4'b0111}) begin
      n_err++;
      $display("FAIL idle_step: ptr=%0d shift_en=%b anode=%b, want 0 0 0111", bus.ptr, bus.shift_en, bus.anode);
    end
`ifdef SCROLL_DIR_EN
    sb.push_back('{ptr: 3'd5, wrap: 1'b1});
`else
    sb.push_back('{ptr: 3'd1, wrap: 1'b0});
`endif
    bus.dir = 1'b1;
    bus.step = 1'b1;
    wait_shift(1, lat);
    bus.step = 1'b0;
    bus.dir = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({bus.ptr, bus.wrap} !== e || lat !== 1) begin
      n_err++;
      $display("FAIL dir_step: ptr=%0d wrap=%b lat=%0d, want ptr=%0d wrap=%b lat=1", bus.ptr, bus.wrap, lat, e.ptr, e.wrap);
    end
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    exp_t e;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) wait_shift(8, lat);
    n_cmp++;
    if (bus.ptr !== 3'd3) begin
      n_err++;
      $display("FAIL pre_reset_ptr: ptr=%0d, want 3", bus.ptr);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.anode, bus.ptr, bus.shift_en, bus.wrap, bus.digit_sel} !== {4'b1111, 3'd0, 1'b0, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL async_reset: anode=%b ptr=%0d sh=%b wr=%b ds=%0d, want 1111/0/0/0/0",
               bus.anode, bus.ptr, bus.shift_en, bus.wrap, bus.digit_sel);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{ptr: 3'd1, wrap: 1'b0});
    wait_shift(8, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== 5) begin
      n_err++;
      $display("FAIL rerun_latency: got %0d, want 5", lat);
    end
    n_cmp++;
    if ({bus.ptr, bus.wrap} !== e) begin
      n_err++;
      $display("FAIL rerun_ptr: ptr=%0d wrap=%b, want ptr=%0d wrap=%b", bus.ptr, bus.wrap, e.ptr, e.wrap);
    end
    bus.run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_wrap();
    test_mux();
    test_step();
    test_run_drop_on_tick();
    test_dir();
    test_reset_mid_run();
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
